reset_sequencer: RTL and testbench

- Generates the reset seen by downstream flops: it drives reset into other logic rather than receiving it.
- Asserts all reset outputs asynchronously and releases them synchronously to the clock, after a hold period, in a staggered order.
- Also accepts a software reset request with a one-cycle acknowledge.
- Sits at the top of each clock domain; its outputs feed the reset inputs of the domain's sync- and async-reset registers.

---
 rtl/reset_seq_pkg.sv | 20 ++
 rtl/reset_sync_chain.sv | 27 ++
 rtl/reset_sequencer.sv | 139 +++++++++++++
 tb/tb_reset_sequencer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the reset sequencer.
package reset_seq_pkg;

  // Sequencer states, in the order a cold start walks through them.
  typedef enum logic [2:0] {
    SYNC    = 3'd0,
    HOLD    = 3'd1,
    RELEASE = 3'd2,
    RUN     = 3'd3,
    SWRST   = 3'd4
  } state_t;

  // Cause codes reported on the optional status port.
  localparam logic [1:0] CAUSE_ASYNC = 2'b01;
  localparam logic [1:0] CAUSE_SW    = 2'b10;

  // Width of the software reset counter on the optional status port.
  localparam int COUNT_W = 8;

endpackage

// File: rtl/reset_sync_chain.sv
// Async-asserted, synchronously-deasserted reset synchronizer.
// o_released goes high SYNC_STAGES rising edges after i_reset falls and
// drops immediately, without a clock, whenever i_reset is high.
module reset_sync_chain
  import reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clock,
  input  logic i_reset,
  output logic o_released
);

  logic [SYNC_STAGES-1:0] r_chain;

  // Shift ones in from stage 0; reset clears the whole chain at once.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_chain <= '0;
    end else begin
      r_chain <= (r_chain << 1) | SYNC_STAGES'(1);
    end
  end

  assign o_released = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: asserts rst_out asynchronously, releases it synchronously
// after a hold period, one bit every GAP_CYCLES edges, bit 0 first.
// A rising edge of sw_rst_req while running restarts the hold/release
// sequence and is acknowledged with a one-cycle sw_rst_ack pulse.
// Optional macro RESET_SEQ_STATUS_EN adds rst_cause and sw_rst_count outputs.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 3,
  parameter int NUM_OUT     = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               sw_rst_req,
  output logic               sw_rst_ack,
  output logic [NUM_OUT-1:0] rst_out,
  output logic               ready
`ifdef RESET_SEQ_STATUS_EN
  ,
  output logic [1:0]         rst_cause,
  output logic [COUNT_W-1:0] sw_rst_count
`endif
);

  localparam int MAX_CNT = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [NUM_OUT-1:0] r_rst_out;
  logic               r_ready;
  logic               r_ack;
  logic               r_req_q;

  logic               w_released;
  logic               w_req_rise;
  logic [NUM_OUT-1:0] w_rst_shift;

  // The state register itself acts as the final synchronizer stage: the
  // chain is one stage shorter, so SYNC->HOLD happens on edge SYNC_STAGES.
  reset_sync_chain #(
    .SYNC_STAGES(SYNC_STAGES - 1)
  ) u_sync (
    .i_clock   (clock),
    .i_reset   (reset),
    .o_released(w_released)
  );

  assign w_req_rise  = sw_rst_req & ~r_req_q;
  // Releasing one more bit, lowest first: 111 -> 110 -> 100 -> 000.
  assign w_rst_shift = r_rst_out << 1;

  // Sequencer FSM with registered outputs; reset forces everything asserted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= SYNC;
      r_cnt     <= '0;
      r_rst_out <= '1;
      r_ready   <= 1'b0;
      r_ack     <= 1'b0;
      r_req_q   <= 1'b0;
    end else begin
      r_req_q <= sw_rst_req;
      r_ack   <= 1'b0;
      case (r_state)
        SYNC: begin
          if (w_released) begin
            r_state <= HOLD;
            r_cnt   <= CNT_W'(HOLD_CYCLES - 1);
          end
        end
        HOLD, RELEASE: begin
          // Both states count down and then release the next bit; HOLD's
          // first release is bit 0, RELEASE handles the remaining bits.
          if (r_cnt == '0) begin
            r_rst_out <= w_rst_shift;
            r_cnt     <= CNT_W'(GAP_CYCLES - 1);
            if (w_rst_shift == '0) begin
              r_state <= RUN;
              r_ready <= 1'b1;
            end else begin
              r_state <= RELEASE;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RUN: begin
          if (w_req_rise) begin
            r_state   <= SWRST;
            r_cnt     <= '0;
            r_rst_out <= '1;
            r_ready   <= 1'b0;
            r_ack     <= 1'b1;
          end
        end
        SWRST: begin
          r_state <= HOLD;
          r_cnt   <= CNT_W'(HOLD_CYCLES - 1);
        end
        default: begin
          r_state   <= SYNC;
          r_rst_out <= '1;
          r_ready   <= 1'b0;
        end
      endcase
    end
  end

  assign rst_out    = r_rst_out;
  assign ready      = r_ready;
  assign sw_rst_ack = r_ack;

`ifdef RESET_SEQ_STATUS_EN
  logic [1:0]         r_cause;
  logic [COUNT_W-1:0] r_sw_count;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // Record why we last reset; only async reset clears the request count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cause    <= CAUSE_ASYNC;
      r_sw_count <= '0;
    end else if (r_state == RUN && w_req_rise) begin
      r_cause    <= CAUSE_SW;
      r_sw_count <= sat_inc(r_sw_count);
    end
  end

  assign rst_cause    = r_cause;
  assign sw_rst_count = r_sw_count;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default instance plus a single-output
// instance (NUM_OUT=1, HOLD_CYCLES=1, SYNC_STAGES=3) sharing the stimulus.
module tb_reset_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       sw_rst_req;
  logic       ack0, rdy0, ack1, rdy1;
  logic [2:0] rst0;
  logic [0:0] rst1;
`ifdef RESET_SEQ_STATUS_EN
  logic [1:0] cause0, cause1;
  logic [7:0] cnt0, cnt1;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  reset_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .sw_rst_req  (sw_rst_req),
    .sw_rst_ack  (ack0),
    .rst_out     (rst0),
    .ready       (rdy0)
`ifdef RESET_SEQ_STATUS_EN
    ,
    .rst_cause   (cause0),
    .sw_rst_count(cnt0)
`endif
  );

  reset_sequencer #(
    .SYNC_STAGES(3),
    .HOLD_CYCLES(1),
    .GAP_CYCLES (3),
    .NUM_OUT    (1)
  ) dut1 (
    .clock       (clock),
    .reset       (reset),
    .sw_rst_req  (sw_rst_req),
    .sw_rst_ack  (ack1),
    .rst_out     (rst1),
    .ready       (rdy1)
`ifdef RESET_SEQ_STATUS_EN
    ,
    .rst_cause   (cause1),
    .sw_rst_count(cnt1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic chk0(input string tag, input int e_rst, input int e_rdy, input int e_ack);
    check({tag, ".rst_out"}, 32'(rst0), e_rst);
    check({tag, ".ready"},   32'(rdy0), e_rdy);
    check({tag, ".ack"},     32'(ack0), e_ack);
  endtask

  task automatic chk1(input string tag, input int e_rst, input int e_rdy);
    check({tag, ".n1_rst_out"}, 32'(rst1), e_rst);
    check({tag, ".n1_ready"},   32'(rdy1), e_rdy);
  endtask

  // Advance n rising edges and settle just after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // One accepted request from RUN, then wait until RUN again (E+11).
  task automatic sw_pulse();
    sw_rst_req = 1'b1;
    tick(1);
    sw_rst_req = 1'b0;
    tick(11);
  endtask

  initial begin
    reset      = 1'b1;
    sw_rst_req = 1'b0;

    // Cold start: outputs asserted while reset is high.
    tick(1);
    chk0("in_reset", 7, 0, 0);
    chk1("in_reset", 1, 0);
    tick(2);
    reset = 1'b0;
    tick(3);  chk0("cold_e3", 7, 0, 0); chk1("cold_e3", 1, 0);
    tick(1);  chk0("cold_e4", 7, 0, 0); chk1("cold_e4", 0, 1);
    tick(1);  chk0("cold_e5", 7, 0, 0);
    tick(1);  chk0("cold_e6", 6, 0, 0);
    tick(2);  chk0("cold_e8", 6, 0, 0);
    tick(1);  chk0("cold_e9", 4, 0, 0);
    tick(2);  chk0("cold_e11", 4, 0, 0);
    tick(1);  chk0("cold_e12", 0, 1, 0);
`ifdef RESET_SEQ_STATUS_EN
    check("cold.cause", 32'(cause0), 1);
    check("cold.count", 32'(cnt0), 0);
`endif

    // Software reset from RUN, captured at edge E.
    sw_rst_req = 1'b1;
    tick(1);  chk0("sw_E", 7, 0, 1); chk1("sw_E", 1, 0);
    check("sw_E.n1_ack", 32'(ack1), 1);
    sw_rst_req = 1'b0;
    tick(1);  chk0("sw_E1", 7, 0, 0); chk1("sw_E1", 1, 0);
    tick(1);  chk1("sw_E2", 0, 1);
    tick(2);  chk0("sw_E4", 7, 0, 0);
    tick(1);  chk0("sw_E5", 6, 0, 0);
    tick(2);  chk0("sw_E7", 6, 0, 0);
    tick(1);  chk0("sw_E8", 4, 0, 0);
    tick(2);  chk0("sw_E10", 4, 0, 0);
    tick(1);  chk0("sw_E11", 0, 1, 0);

    // Short async reset glitch mid-RELEASE: immediate reassertion, restart.
    sw_rst_req = 1'b1;
    tick(1);
    sw_rst_req = 1'b0;
    tick(6);  chk0("mid_E6", 6, 0, 0);
    reset = 1'b1;
    #2;
    chk0("glitch_async", 7, 0, 0);
    chk1("glitch_async", 1, 0);
    reset = 1'b0;
    tick(5);  chk0("restart_e5", 7, 0, 0);
    tick(1);  chk0("restart_e6", 6, 0, 0);
    tick(6);  chk0("restart_e12", 0, 1, 0);

    // Request held across async reset, then a rising edge during HOLD.
    reset      = 1'b1;
    sw_rst_req = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);  chk0("held_e1", 7, 0, 0);
    tick(1);
    sw_rst_req = 1'b0;
    tick(1);
    sw_rst_req = 1'b1;
    tick(1);  chk0("hold_edge_e4", 7, 0, 0);
    tick(2);  chk0("hold_edge_e6", 6, 0, 0);
    tick(3);  chk0("hold_edge_e9", 4, 0, 0);
    tick(3);  chk0("hold_edge_e12", 0, 1, 0);
    tick(2);  chk0("held_run_e14", 0, 1, 0);
    sw_rst_req = 1'b0;
    tick(1);
    sw_rst_req = 1'b1;
    tick(1);  chk0("clean_E", 7, 0, 1);
    sw_rst_req = 1'b0;
    tick(11); chk0("clean_E11", 0, 1, 0);

`ifdef RESET_SEQ_STATUS_EN
    // One request accepted since the last async reset; two more make three.
    sw_pulse();
    sw_pulse();
    check("stat3.count", 32'(cnt0), 3);
    check("stat3.cause", 32'(cause0), 2);
    reset = 1'b1;
    #2;
    check("stat_async.count", 32'(cnt0), 0);
    check("stat_async.cause", 32'(cause0), 1);
    tick(1);
    reset = 1'b0;
    tick(12);
    for (int i = 0; i < 300; i++) sw_pulse();
    check("stat_sat.count", 32'(cnt0), 255);
    check("stat_sat.cause", 32'(cause0), 2);
    chk0("stat_sat_run", 0, 1, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
